// File: rtl/sram_bus_arbiter.sv
// Purpose: shares one SRAM-like port between instruction fetch (master 0) and load/store (master 1),
//          with data priority, a fetch starvation guard and an in-order owner FIFO for response routing.
// Latency: zero added cycles; request and response paths are purely combinational muxes.
// Backpressure: mem_addr_ok stalls the granted master (the grant is held until the accept);
//               mem_req drops while OUTSTANDING transfers are unanswered.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_* / data_*               master request fields (req, wr, size, wstrb, addr, wdata) and
//                                 handshakes (addr_ok, data_ok, rdata)
//   mem_*                         shared memory port request fields and accept/response
//   err_stray                     sticky: response arrived with nothing outstanding
module sram_bus_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_stray
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Owner FIFO: one bit per outstanding transfer, 0 = inst, 1 = data.
  logic [OUTSTANDING-1:0] owner;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  logic          hold;     // a request is presented but not yet accepted
  logic          grant_q;  // master owning the held request
  logic [SW-1:0] starve;   // consecutive data accepts while fetch waits

  logic grant;             // 1 = data master
  logic sel_req;
  logic push;
  logic pop;
  logic stray;
  logic head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    grant = 1'b0;
    if (hold)                                                grant = grant_q;
    else if (starve == SW'(STARVE_LIMIT) && inst_req)        grant = 1'b0;
    else if (data_req)                                       grant = 1'b1;
    else                                                     grant = 1'b0;
  end

  assign sel_req = grant ? data_req : inst_req;
  // A full FIFO blocks the request even if a pop happens this cycle.
  assign mem_req = sel_req & (count < CW'(OUTSTANDING));
  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & (count != '0);
  assign stray   = mem_data_ok & (count == '0);
  assign head    = owner[rd_ptr];

  assign mem_wr    = grant ? data_wr    : inst_wr;
  assign mem_size  = grant ? data_size  : inst_size;
  assign mem_wstrb = grant ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant ? data_addr  : inst_addr;
  assign mem_wdata = grant ? data_wdata : inst_wdata;

  assign inst_addr_ok = push & ~grant;
  assign data_addr_ok = push &  grant;
  assign inst_data_ok = pop  & ~head;
  assign data_data_ok = pop  &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold      <= 1'b0;
      grant_q   <= 1'b0;
      starve    <= '0;
      err_stray <= 1'b0;
    end else begin
      if (push) begin
        owner[wr_ptr] <= grant;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (push) begin
        hold <= 1'b0;
      end else if (mem_req) begin
        hold    <= 1'b1;
        grant_q <= grant;
      end

      if (push && !grant)                                  starve <= '0;
      else if (!inst_req)                                  starve <= '0;
      else if (push && grant && starve != SW'(STARVE_LIMIT)) starve <= starve + SW'(1);

      if (stray) err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int OUTSTANDING  = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk, reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_stray;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_bus_arbiter #(.OUTSTANDING(OUTSTANDING), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Master request registers (index 0 = inst, 1 = data).
  bit          pend[2];
  logic        wr[2];
  logic [1:0]  sz[2];
  logic [3:0]  st[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];

  // Stimulus knobs.
  int p_req, p_aok, p_dok;
  bit no_new, force_stray;

  // Reference model state: ordered owners of outstanding transfers,
  // consecutive data wins while fetch waits, master whose request is stuck.
  int owner_q[$];
  int starve;
  int held;
  bit m_err;

  // Memory responder and scoreboard queues.
  logic [31:0] resp_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          acc_log[$];

  function automatic logic [31:0] rsp(input logic [31:0] a, input logic w);
    return w ? {16'hC0DE, a[15:0]} : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (held >= 0) return held;
    if (starve == STARVE_LIMIT && pend[0]) return 0;
    if (pend[1]) return 1;
    return 0;
  endfunction

  task automatic drive_masters();
    inst_req = pend[0]; inst_wr = wr[0]; inst_size = sz[0]; inst_wstrb = st[0];
    inst_addr = ad[0];  inst_wdata = wd[0];
    data_req = pend[1]; data_wr = wr[1]; data_size = sz[1]; data_wstrb = st[1];
    data_addr = ad[1];  data_wdata = wd[1];
  endtask

  task automatic step();
    int  g;
    bit  exp_req, dok_v, a0, a1, acc;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!pend[m] && !no_new && $urandom_range(99) < p_req) begin
        pend[m] = 1'b1;
        wr[m]   = (m == 1) ? 1'($urandom_range(1)) : 1'b0;
        sz[m]   = 2'($urandom_range(2));
        st[m]   = 4'($urandom);
        ad[m]   = $urandom;
        wd[m]   = $urandom;
      end
    end
    drive_masters();
    mem_addr_ok = ($urandom_range(99) < p_aok);
    dok_v       = (resp_q.size() > 0) && ($urandom_range(99) < p_dok);
    mem_data_ok = dok_v | force_stray;
    mem_rdata   = dok_v ? resp_q[0] : $urandom;
    #1;
    g       = model_grant();
    exp_req = pend[g] && (owner_q.size() < OUTSTANDING);
    chk("mem_req", mem_req, exp_req);
    if (exp_req)
      chk("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
          {wr[g], sz[g], st[g], ad[g], wd[g]});
    chk("inst_addr_ok", inst_addr_ok, exp_req && mem_addr_ok && g == 0);
    chk("data_addr_ok", data_addr_ok, exp_req && mem_addr_ok && g == 1);
    chk("inst_data_ok", inst_data_ok, mem_data_ok && owner_q.size() > 0 && owner_q[0] == 0);
    chk("data_data_ok", data_data_ok, mem_data_ok && owner_q.size() > 0 && owner_q[0] == 1);
    chk("err_stray", err_stray, m_err);
    a0 = inst_addr_ok;
    a1 = data_addr_ok;
    if (a0) begin exp_q0.push_back(rsp(inst_addr, inst_wr)); acc_log.push_back(0); end
    if (a1) begin exp_q1.push_back(rsp(data_addr, data_wr)); acc_log.push_back(1); end
    if (mem_req && mem_addr_ok) resp_q.push_back(rsp(mem_addr, mem_wr));
    @(posedge clk);
    acc = exp_req && mem_addr_ok;
    if (mem_data_ok) begin
      if (owner_q.size() > 0) void'(owner_q.pop_front());
      else m_err = 1'b1;
    end
    if (acc) begin
      owner_q.push_back(g);
      held = -1;
    end else if (exp_req) begin
      held = g;
    end
    if (acc && g == 0)                                   starve = 0;
    else if (!pend[0])                                   starve = 0;
    else if (acc && g == 1 && starve < STARVE_LIMIT)     starve++;
    if (a0) pend[0] = 1'b0;
    if (a1) pend[1] = 1'b0;
    if (dok_v) void'(resp_q.pop_front());
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_masters();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; force_stray = 1'b0;
    repeat (n) @(posedge clk);
    owner_q.delete(); resp_q.delete(); exp_q0.delete(); exp_q1.delete();
    starve = 0; held = -1; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_err_stray", err_stray, 0);
  endtask

  // Response monitor: pops the expected read data for whichever master sees data_ok.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (inst_data_ok) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL inst_rsp_unexpected actual=%0h expected=none", inst_rdata);
        end else chk("inst_rdata", inst_rdata, exp_q0.pop_front());
      end
      if (data_data_ok) begin
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL data_rsp_unexpected actual=%0h expected=none", data_rdata);
        end else chk("data_rdata", data_rdata, exp_q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int exp_order[6];
    int guard;
    exp_order = '{1, 1, 1, 1, 0, 1};
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; wr[m] = 1'b0; sz[m] = '0; st[m] = '0; ad[m] = '0; wd[m] = '0;
    end
    drive_masters();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    no_new = 1'b0; force_stray = 1'b0;
    p_req = 0; p_aok = 0; p_dok = 0;
    do_reset(2);

    // Both masters requesting back to back: data wins until the guard forces fetch.
    p_req = 100; p_aok = 100; p_dok = 100;
    acc_log.delete();
    repeat (20) step();
    if (acc_log.size() < 6) begin
      checks++; failures++;
      $display("FAIL starve_order accepts=%0d required=6", acc_log.size());
    end else begin
      for (int i = 0; i < 6; i++) chk("starve_order", acc_log[i], exp_order[i]);
    end

    // Fill the owner FIFO with no responses, then release it.
    p_dok = 0;
    repeat (5) step();
    p_dok = 100;
    repeat (4) step();

    // Randomised traffic with random memory backpressure and response timing.
    p_req = 60; p_aok = 60; p_dok = 50;
    repeat (3000) step();

    // Drain everything still in flight.
    no_new = 1'b1; p_aok = 100; p_dok = 100;
    guard = 0;
    while ((pend[0] || pend[1] || resp_q.size() > 0) && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_done", guard < 100, 1);
    chk("inst_rsp_all_seen", exp_q0.size(), 0);
    chk("data_rsp_all_seen", exp_q1.size(), 0);

    // Stray response with nothing outstanding; flag must stick until reset.
    p_req = 0; no_new = 1'b0;
    force_stray = 1'b1;
    step();
    force_stray = 1'b0;
    repeat (3) step();
    chk("err_stray_sticky", err_stray, 1);
    do_reset(1);
    p_req = 100; p_aok = 100; p_dok = 100;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
